// File: rtl/fft_unload_if.sv
// Frame-in / sample-out handshake bundle between the FFT output FIFOs,
// the unloader and the narrow sample FIFO.
interface fft_unload_if #(
    parameter int DATA_CNT   = 32,
    parameter int IDX_WIDTH  = $clog2(DATA_CNT),
    parameter int DATA_WIDTH = 32
);
    logic [DATA_CNT*DATA_WIDTH-1:0] re_din;
    logic [DATA_CNT*DATA_WIDTH-1:0] im_din;
    logic                           re_empty;
    logic                           im_empty;
    logic                           re_rd_en;
    logic                           im_rd_en;
    logic                           out_full;
    logic                           out_wr_en;
    logic [2*DATA_WIDTH-1:0]        out_dout;
    logic [IDX_WIDTH-1:0]           out_idx;

    modport master (
        input  re_din, im_din, re_empty, im_empty, out_full,
        output re_rd_en, im_rd_en, out_wr_en, out_dout, out_idx
    );

    modport slave (
        output re_din, im_din, re_empty, im_empty, out_full,
        input  re_rd_en, im_rd_en, out_wr_en, out_dout, out_idx
    );
endinterface

// File: rtl/fft_unload.sv
// Pops one complete FFT frame (real + imaginary vectors) and serialises it
// into single complex samples, optionally undoing the FFT's bit-reversed order.
module fft_unload #(
    parameter int DATA_CNT    = 32,
    parameter int IDX_WIDTH   = $clog2(DATA_CNT),
    parameter int DATA_WIDTH  = 32,
    parameter int BIT_REVERSE = 1
) (
    input  logic         clock,
    input  logic         reset,
    fft_unload_if.master bus
);
    localparam int                   FRAME_W  = DATA_CNT * DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_CNT - 1);
    localparam logic [IDX_WIDTH-1:0] ONE_IDX  = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0] ZERO_IDX = {IDX_WIDTH{1'b0}};

    typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d, idx_s;
    logic [FRAME_W-1:0]   re_buf_q, re_buf_d, im_buf_q, im_buf_d;
    logic                 avail_s, pop_s, wr_s;

    function automatic logic [IDX_WIDTH-1:0] bitrev(input logic [IDX_WIDTH-1:0] v);
        logic [IDX_WIDTH-1:0] r;
        r = {IDX_WIDTH{1'b0}};
        for (int i = 0; i < IDX_WIDTH; i++) begin
            r[i] = v[IDX_WIDTH-1-i];
        end
        return r;
    endfunction

    // State, sample counter and frame buffers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= ZERO_IDX;
            re_buf_q <= {FRAME_W{1'b0}};
            im_buf_q <= {FRAME_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            re_buf_q <= re_buf_d;
            im_buf_q <= im_buf_d;
        end
    end

    // Next-state, pop and write decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop_s   = 1'b0;
        wr_s    = 1'b0;
        avail_s = !bus.re_empty && !bus.im_empty;
        if (BIT_REVERSE != 0) begin
            idx_s = bitrev(cnt_q);
        end else begin
            idx_s = cnt_q;
        end
        case (state_q)
            IDLE: begin
                if (avail_s) begin
                    pop_s   = 1'b1;
                    cnt_d   = ZERO_IDX;
                    state_d = EMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                wr_s = !bus.out_full;
                // A new frame may only be popped on the final write so samples stream without a bubble
                if (wr_s && (cnt_q == LAST_IDX)) begin
                    pop_s = avail_s;
                    cnt_d = ZERO_IDX;
                    if (avail_s) begin
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wr_s) begin
                    cnt_d = cnt_q + ONE_IDX;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = ZERO_IDX;
            end
        endcase
        if (pop_s) begin
            re_buf_d = bus.re_din;
            im_buf_d = bus.im_din;
        end else begin
            re_buf_d = re_buf_q;
            im_buf_d = im_buf_q;
        end
    end

    assign bus.re_rd_en  = pop_s;
    assign bus.im_rd_en  = pop_s;
    assign bus.out_wr_en = wr_s;
    assign bus.out_idx   = idx_s;
    assign bus.out_dout  = {re_buf_q[int'(idx_s)*DATA_WIDTH +: DATA_WIDTH],
                            im_buf_q[int'(idx_s)*DATA_WIDTH +: DATA_WIDTH]};
endmodule

// File: tb/tb_fft_unload.sv
// Self-checking bench: a bit-reversing and a natural-order unloader share one
// frame source; a frame/sample queue model predicts pops, writes and data.
module tb_fft_unload;
    localparam int N  = 32;
    localparam int W  = 32;
    localparam int IW = 5;
    localparam int FW = N * W;
    localparam int SW = 2 * W + IW;

    typedef logic [SW-1:0] samp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fft_unload_if #(.DATA_CNT(N), .IDX_WIDTH(IW), .DATA_WIDTH(W)) bus_rev ();
    fft_unload_if #(.DATA_CNT(N), .IDX_WIDTH(IW), .DATA_WIDTH(W)) bus_nat ();

    fft_unload #(.DATA_CNT(N), .IDX_WIDTH(IW), .DATA_WIDTH(W), .BIT_REVERSE(1)) dut_rev (
        .clock(clock), .reset(reset), .bus(bus_rev));
    fft_unload #(.DATA_CNT(N), .IDX_WIDTH(IW), .DATA_WIDTH(W), .BIT_REVERSE(0)) dut_nat (
        .clock(clock), .reset(reset), .bus(bus_nat));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [FW-1:0] src_re[$];
    logic [FW-1:0] src_im[$];
    samp_t         exp_rev[$];
    samp_t         exp_nat[$];
    logic          full_r   = 1'b0;
    logic          im_block = 1'b0;

    logic [5:0]      obs_ctl, exp_ctl;
    logic [2*SW-1:0] obs_data, exp_data;
    logic            exp_wr, exp_pop, obs_wr, obs_pop;

    function automatic int rev_of(input int k);
        int r;
        int v;
        r = 0;
        v = k;
        for (int i = 0; i < IW; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic drive_inputs();
        logic [FW-1:0] re_v;
        logic [FW-1:0] im_v;
        logic          re_e;
        logic          im_e;
        re_v = {FW{1'b0}};
        im_v = {FW{1'b0}};
        if (src_re.size() > 0) begin
            re_v = src_re[0];
            im_v = src_im[0];
        end
        re_e = (src_re.size() == 0);
        im_e = re_e || im_block;
        bus_rev.re_din = re_v;  bus_nat.re_din = re_v;
        bus_rev.im_din = im_v;  bus_nat.im_din = im_v;
        bus_rev.re_empty = re_e; bus_nat.re_empty = re_e;
        bus_rev.im_empty = im_e; bus_nat.im_empty = im_e;
        bus_rev.out_full = full_r; bus_nat.out_full = full_r;
    endtask

    task automatic load_frame(input bit ramp);
        logic [FW-1:0] r;
        logic [FW-1:0] m;
        for (int k = 0; k < N; k++) begin
            if (ramp) begin
                r[k*W +: W] = W'(k);
                m[k*W +: W] = W'(-k);
            end else begin
                r[k*W +: W] = $urandom;
                m[k*W +: W] = $urandom;
            end
        end
        src_re.push_back(r);
        src_im.push_back(m);
        drive_inputs();
    endtask

    // One clock: observe at the falling edge, update the queue model, then drive.
    task automatic advance();
        logic avail;
        int   b;
        @(negedge clock);
        avail   = (src_re.size() > 0) && !im_block;
        exp_wr  = (exp_rev.size() > 0) && !full_r;
        exp_pop = avail && ((exp_rev.size() == 0) || ((exp_rev.size() == 1) && exp_wr));
        obs_ctl = {bus_rev.re_rd_en, bus_rev.im_rd_en, bus_rev.out_wr_en,
                   bus_nat.re_rd_en, bus_nat.im_rd_en, bus_nat.out_wr_en};
        exp_ctl = {exp_pop, exp_pop, exp_wr, exp_pop, exp_pop, exp_wr};
        obs_data = {bus_rev.out_dout, bus_rev.out_idx, bus_nat.out_dout, bus_nat.out_idx};
        exp_data = {(2*SW){1'b0}};
        obs_wr  = bus_rev.out_wr_en;
        obs_pop = bus_rev.re_rd_en;
        if (exp_wr) begin
            exp_data = {exp_rev[0], exp_nat[0]};
            void'(exp_rev.pop_front());
            void'(exp_nat.pop_front());
        end
        if (exp_pop) begin
            for (int k = 0; k < N; k++) begin
                b = rev_of(k);
                exp_rev.push_back({src_re[0][b*W +: W], src_im[0][b*W +: W], IW'(b)});
                exp_nat.push_back({src_re[0][k*W +: W], src_im[0][k*W +: W], IW'(k)});
            end
        end
        if (reset) begin
            exp_rev.delete();
            exp_nat.delete();
        end
        @(posedge clock);
        #1;
        if (exp_pop) begin
            void'(src_re.pop_front());
            void'(src_im.pop_front());
        end
        cyc++;
        drive_inputs();
    endtask

    task automatic test_reset();
        logic [2*(3+2*W+IW)-1:0] obs_all;
        reset = 1'b1;
        drive_inputs();
        advance();
        advance();
        reset = 1'b0;
        obs_all = {bus_rev.re_rd_en, bus_rev.im_rd_en, bus_rev.out_wr_en, bus_rev.out_dout, bus_rev.out_idx,
                   bus_nat.re_rd_en, bus_nat.im_rd_en, bus_nat.out_wr_en, bus_nat.out_dout, bus_nat.out_idx};
        checks++;
        if (obs_all !== {(2*(3+2*W+IW)){1'b0}}) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", obs_all);
        end
    endtask

    task automatic test_ramp();
        int nwr, npop, first_pop, first_wr;
        nwr = 0; npop = 0; first_pop = -1; first_wr = -1;
        load_frame(1'b1);
        for (int c = 0; c < 40; c++) begin
            advance();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL ramp_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl);
            end
            if (exp_wr) begin
                checks++;
                if (obs_data !== exp_data) begin
                    failures++; $display("FAIL ramp_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data);
                end
            end
            if (obs_pop) begin npop++; if (first_pop < 0) first_pop = c; end
            if (obs_wr) begin nwr++; if (first_wr < 0) first_wr = c; end
        end
        checks++;
        if (nwr != N || npop != 1 || first_wr - first_pop != 1) begin
            failures++;
            $display("FAIL ramp_counts writes=%0d pops=%0d latency=%0d want 32/1/1", nwr, npop, first_wr - first_pop);
        end
    endtask

    task automatic test_backpressure();
        int nwr, held;
        nwr = 0; held = 0;
        load_frame(1'b0);
        for (int c = 0; c < 50; c++) begin
            if (nwr == 4 && held < 5) begin full_r = 1'b1; held++; end
            else begin full_r = 1'b0; end
            drive_inputs();
            advance();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL bp_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl);
            end
            if (exp_wr) begin
                checks++;
                if (obs_data !== exp_data) begin
                    failures++; $display("FAIL bp_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data);
                end
            end
            if (obs_wr) nwr++;
        end
        full_r = 1'b0;
        drive_inputs();
        checks++;
        if (nwr != N || held != 5) begin
            failures++; $display("FAIL bp_counts writes=%0d held=%0d want 32/5", nwr, held);
        end
    endtask

    task automatic test_back_to_back();
        int nwr, npop, first_wr, last_wr, pop2_c, wr32_c;
        nwr = 0; npop = 0; first_wr = -1; last_wr = -1; pop2_c = -1; wr32_c = -2;
        load_frame(1'b0);
        load_frame(1'b0);
        for (int c = 0; c < 80; c++) begin
            advance();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL b2b_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl);
            end
            if (exp_wr) begin
                checks++;
                if (obs_data !== exp_data) begin
                    failures++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data);
                end
            end
            if (obs_pop) begin npop++; if (npop == 2) pop2_c = c; end
            if (obs_wr) begin
                nwr++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                if (nwr == N) wr32_c = c;
            end
        end
        checks++;
        if (nwr != 2 * N || last_wr - first_wr != 2 * N - 1 || pop2_c != wr32_c) begin
            failures++;
            $display("FAIL b2b_stream writes=%0d span=%0d pop2=%0d wr32=%0d want 64/63/equal",
                     nwr, last_wr - first_wr, pop2_c, wr32_c);
        end
    endtask

    task automatic test_asym_empty();
        im_block = 1'b1;
        load_frame(1'b0);
        for (int c = 0; c < 10; c++) begin
            advance();
            checks++;
            if (obs_ctl !== 6'b000000) begin
                failures++; $display("FAIL asym_hold cyc=%0d got=%b want=000000", cyc, obs_ctl);
            end
        end
        im_block = 1'b0;
        drive_inputs();
        advance();
        checks++;
        if (obs_ctl !== exp_ctl || obs_ctl[5:4] !== 2'b11 || obs_ctl[2:1] !== 2'b11) begin
            failures++; $display("FAIL asym_pop cyc=%0d got=%b want=110110", cyc, obs_ctl);
        end
        for (int c = 0; c < 36; c++) begin
            advance();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL asym_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl);
            end
            if (exp_wr) begin
                checks++;
                if (obs_data !== exp_data) begin
                    failures++; $display("FAIL asym_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nwr;
        logic [2*(3+2*W+IW)-1:0] obs_all;
        nwr = 0;
        load_frame(1'b0);
        for (int c = 0; c < 50 && nwr < 10; c++) begin
            advance();
            if (obs_wr) nwr++;
        end
        checks++;
        if (nwr != 10) begin
            failures++; $display("FAIL rmid_prefix writes=%0d want=10", nwr);
        end
        reset = 1'b1;
        advance();
        reset = 1'b0;
        obs_all = {bus_rev.re_rd_en, bus_rev.im_rd_en, bus_rev.out_wr_en, bus_rev.out_dout, bus_rev.out_idx,
                   bus_nat.re_rd_en, bus_nat.im_rd_en, bus_nat.out_wr_en, bus_nat.out_dout, bus_nat.out_idx};
        checks++;
        if (obs_all !== {(2*(3+2*W+IW)){1'b0}}) begin
            failures++; $display("FAIL rmid_zero got=%h want=0", obs_all);
        end
        nwr = 0;
        load_frame(1'b1);
        for (int c = 0; c < 40; c++) begin
            advance();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL rmid_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl);
            end
            if (exp_wr) begin
                checks++;
                if (obs_data !== exp_data) begin
                    failures++; $display("FAIL rmid_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data);
                end
            end
            if (obs_wr) nwr++;
        end
        checks++;
        if (nwr != N) begin
            failures++; $display("FAIL rmid_count writes=%0d want=32", nwr);
        end
    endtask

    task automatic test_random();
        int nwr, loaded;
        nwr = 0; loaded = 0;
        for (int c = 0; c < 400; c++) begin
            if (c < 300 && loaded < 4 && $urandom_range(0, 19) == 0) begin
                load_frame(1'b0);
                loaded++;
            end
            full_r = (c < 300) && ($urandom_range(0, 9) < 3);
            drive_inputs();
            advance();
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", cyc, obs_ctl, exp_ctl);
            end
            if (exp_wr) begin
                checks++;
                if (obs_data !== exp_data) begin
                    failures++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data);
                end
            end
            if (obs_wr) nwr++;
        end
        full_r = 1'b0;
        drive_inputs();
        checks++;
        if (nwr != loaded * N) begin
            failures++; $display("FAIL rand_count writes=%0d want=%0d", nwr, loaded * N);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_back_to_back();
        test_asym_empty();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
